// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port between
// NCLIENT strobe/done clients. Only one toggle is ever outstanding.
module sdram_port_arbiter #(
    parameter int NCLIENT = 3,
    parameter int AW      = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCLIENT-1:0]    cl_stb,
    input  logic [NCLIENT-1:0]    cl_we,
    input  logic [NCLIENT*AW-1:0] cl_a,
    input  logic [NCLIENT*2-1:0]  cl_ds,
    input  logic [NCLIENT*16-1:0] cl_d,
    output logic [NCLIENT-1:0]    cl_done,
    output logic [15:0]           cl_q,
    output logic [NCLIENT-1:0]    cl_ovr,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_a,
    output logic [1:0]            mem_ds,
    output logic [15:0]           mem_d,
    input  logic [15:0]           mem_q,
    output logic                  busy
);

    localparam int IW = (NCLIENT > 2) ? 2 : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state;
    logic [NCLIENT-1:0]  pend;
    logic [NCLIENT-1:0]  lat_we;
    logic [AW-1:0]       lat_a  [NCLIENT];
    logic [1:0]          lat_ds [NCLIENT];
    logic [15:0]         lat_d  [NCLIENT];
    logic [IW-1:0]       g;
    logic [IW-1:0]       last;
    logic [IW-1:0]       sel;
    logic [IW-1:0]       cand;
    logic                any_pend;
    logic                xfer_done;

    assign xfer_done = (state == S_WAIT) && (mem_ack == mem_req);

    // Search starts just after the last served client so nobody starves.
    always_comb begin
        sel      = last;
        cand     = last;
        any_pend = 1'b0;
        for (int k = 1; k <= NCLIENT; k++) begin
            cand = IW'((int'(last) + k) % NCLIENT);
            if (!any_pend && pend[cand]) begin
                sel      = cand;
                any_pend = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCLIENT; i++) begin : g_client
        logic          clr;
        logic          accept;
        logic          pend_r;
        logic          ovr_r;
        logic          we_r;
        logic [AW-1:0] a_r;
        logic [1:0]    ds_r;
        logic [15:0]   d_r;

        // A strobe landing on the completion cycle refills the slot, not an overrun.
        assign clr    = xfer_done && (g == IW'(i));
        assign accept = cl_stb[i] && (!pend_r || clr);

        always_ff @(posedge clk) begin
            if (reset) begin
                pend_r <= 1'b0;
                ovr_r  <= 1'b0;
            end else begin
                if (accept)
                    pend_r <= 1'b1;
                else if (clr)
                    pend_r <= 1'b0;
                if (cl_stb[i] && !accept)
                    ovr_r <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                we_r <= cl_we[i];
                a_r  <= cl_a[i*AW +: AW];
                ds_r <= cl_ds[i*2 +: 2];
                d_r  <= cl_d[i*16 +: 16];
            end
        end

        assign pend[i]   = pend_r;
        assign cl_ovr[i] = ovr_r;
        assign lat_we[i] = we_r;
        assign lat_a[i]  = a_r;
        assign lat_ds[i] = ds_r;
        assign lat_d[i]  = d_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            g       <= '0;
            last    <= IW'(NCLIENT - 1);
            mem_req <= mem_ack;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_ds  <= '0;
            mem_d   <= '0;
            cl_done <= '0;
            cl_q    <= '0;
            busy    <= 1'b0;
        end else begin
            cl_done <= '0;
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        g       <= sel;
                        mem_we  <= lat_we[sel];
                        mem_a   <= lat_a[sel];
                        mem_ds  <= lat_ds[sel];
                        mem_d   <= lat_d[sel];
                        mem_req <= ~mem_req;
                        busy    <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack == mem_req) begin
                        if (!mem_we)
                            cl_q <= mem_q;
                        cl_done[g] <= 1'b1;
                        last       <= g;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all checked against a transaction-level model.
module tb_sdram_port_arbiter;

    localparam int NC = 3;
    localparam int AW = 23;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    cl_stb, cl_we;
    logic [NC*AW-1:0] cl_a;
    logic [NC*2-1:0]  cl_ds;
    logic [NC*16-1:0] cl_d;
    logic [NC-1:0]    cl_done;
    logic [15:0]      cl_q;
    logic [NC-1:0]    cl_ovr;
    logic             mem_req, mem_ack, mem_we, busy;
    logic [AW-1:0]    mem_a;
    logic [1:0]       mem_ds;
    logic [15:0]      mem_d, mem_q;

    sdram_port_arbiter #(.NCLIENT(NC), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cl_stb(cl_stb), .cl_we(cl_we), .cl_a(cl_a), .cl_ds(cl_ds), .cl_d(cl_d),
        .cl_done(cl_done), .cl_q(cl_q), .cl_ovr(cl_ovr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a),
        .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [NC-1:0] m_pend, m_ovr, m_we;
    logic [AW-1:0] m_a  [NC];
    logic [1:0]    m_ds [NC];
    logic [15:0]   m_d  [NC];
    int            m_cur, m_last, m_dc;
    logic          m_req;
    logic [15:0]   m_q;
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [1:0]    e_ds;
    logic [15:0]   e_d;

    // controller responder state
    bit          rand_mode;
    bit          resp_active;
    int          ack_delay, cnt;
    logic [15:0] resp_q;
    int          done_cnt [NC];
    int          done_log [$];

    typedef struct {
        int          client;
        logic        we;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        logic [15:0] q;
        int          delay;
        logic [15:0] exp_cl_q;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic strobe(input int c, input logic we, input logic [22:0] a,
                          input logic [1:0] ds, input logic [15:0] d);
        cl_stb[c]         = 1'b1;
        cl_we[c]          = we;
        cl_a[c*AW +: AW]  = a;
        cl_ds[c*2 +: 2]   = ds;
        cl_d[c*16 +: 16]  = d;
    endtask

    // One transaction at a time; grant picks the first pending client after the last served.
    task automatic model_update();
        int  dc;
        int  c;
        bit  found;
        dc = -1;
        if (reset) begin
            m_pend = '0; m_ovr = '0; m_cur = -1; m_last = NC - 1;
            m_req = mem_ack; m_q = '0;
            e_we = 1'b0; e_a = '0; e_ds = '0; e_d = '0;
        end else begin
            if (m_cur >= 0) begin
                if (mem_ack == m_req) begin
                    dc = m_cur;
                    if (!e_we) m_q = mem_q;
                    m_last = m_cur;
                    m_cur = -1;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last + k) % NC;
                    if (!found && m_pend[c]) begin
                        found = 1'b1;
                        m_cur = c;
                    end
                end
                if (found) begin
                    e_we = m_we[m_cur]; e_a = m_a[m_cur]; e_ds = m_ds[m_cur]; e_d = m_d[m_cur];
                    m_req = ~m_req;
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (cl_stb[i]) begin
                    if (m_pend[i] && dc != i) m_ovr[i] = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_we[i]   = cl_we[i];
                        m_a[i]    = cl_a[i*AW +: AW];
                        m_ds[i]   = cl_ds[i*2 +: 2];
                        m_d[i]    = cl_d[i*16 +: 16];
                    end
                end else if (dc == i) begin
                    m_pend[i] = 1'b0;
                end
            end
        end
        m_dc = dc;
    endtask

    task automatic compare();
        logic [NC-1:0] ed;
        ed = '0;
        if (m_dc >= 0) ed[m_dc] = 1'b1;
        check("cl_done", cl_done, ed);
        check("cl_q", cl_q, m_q);
        check("cl_ovr", cl_ovr, m_ovr);
        check("mem_req", mem_req, m_req);
        check("busy", busy, m_cur >= 0);
        check("mem_we", mem_we, e_we);
        check("mem_a", mem_a, e_a);
        check("mem_ds", mem_ds, e_ds);
        check("mem_d", mem_d, e_d);
    endtask

    task automatic responder();
        if (reset) begin
            resp_active = 1'b0;
        end else begin
            if (!resp_active && mem_req !== mem_ack) begin
                resp_active = 1'b1;
                if (rand_mode) begin
                    ack_delay = $urandom_range(0, 5);
                    resp_q    = 16'($urandom);
                end
                cnt = ack_delay;
            end
            if (resp_active && cnt == 0) begin
                mem_ack     = mem_req;
                mem_q       = resp_q;
                resp_active = 1'b0;
            end else begin
                if (resp_active) cnt--;
                mem_q = 16'($urandom);
            end
        end
    endtask

    task automatic random_stimulus();
        for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 4) == 0)
                strobe(c, 1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
        for (int c = 0; c < NC; c++)
            if (cl_done[c] === 1'b1) begin
                done_cnt[c]++;
                done_log.push_back(c);
            end
        cl_stb = '0;
        responder();
        if (rand_mode) random_stimulus();
    endtask

    task automatic wait_done(input int c, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            if (cl_done[c] === 1'b1) seen = 1'b1;
        end
        check($sformatf("done_seen_c%0d", c), seen, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, c0, sum0;

        cl_stb = '0; cl_we = '0; cl_a = '0; cl_ds = '0; cl_d = '0;
        mem_ack = 1'b1; mem_q = '0; rand_mode = 1'b0; resp_active = 1'b0;
        ack_delay = 2; cnt = 0; resp_q = '0;
        m_pend = '0; m_ovr = '0; m_we = '0; m_cur = -1; m_last = NC - 1; m_dc = -1;
        m_req = 1'b1; m_q = '0; e_we = 1'b0; e_a = '0; e_ds = '0; e_d = '0;
        for (int i = 0; i < NC; i++) begin
            done_cnt[i] = 0; m_a[i] = '0; m_ds[i] = '0; m_d[i] = '0;
        end

        vecs[0] = '{1, 1'b0, 23'h012345, 2'b11, 16'h0000, 16'hBEEF, 8, 16'hBEEF};
        vecs[1] = '{0, 1'b1, 23'h000777, 2'b01, 16'h55AA, 16'h1234, 3, 16'hBEEF};
        vecs[2] = '{2, 1'b0, 23'h7FFFFF, 2'b10, 16'h0000, 16'h0000, 0, 16'h0000};
        vecs[3] = '{1, 1'b1, 23'h000000, 2'b11, 16'hFFFF, 16'hAAAA, 1, 16'h0000};
        vecs[4] = '{0, 1'b0, 23'h400000, 2'b01, 16'h0000, 16'h8001, 2, 16'h8001};

        // reset with no traffic
        do_reset(3);
        check("rst_mem_req", mem_req, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cl_q", cl_q, 16'h0);
        repeat (20) step();
        check("idle_mem_req", mem_req, 1'b1);
        check("idle_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);

        // directed vector table
        for (int v = 0; v < 5; v++) begin
            ack_delay = vecs[v].delay;
            resp_q    = vecs[v].q;
            strobe(vecs[v].client, vecs[v].we, vecs[v].a, vecs[v].ds, vecs[v].d);
            step();
            check("issue_lat_busy0", busy, 1'b0);
            step();
            check("issue_lat_busy1", busy, 1'b1);
            check("vec_mem_a", mem_a, vecs[v].a);
            check("vec_mem_we", mem_we, vecs[v].we);
            check("vec_mem_ds", mem_ds, vecs[v].ds);
            if (vecs[v].we) check("vec_mem_d", mem_d, vecs[v].d);
            wait_done(vecs[v].client, vecs[v].delay + 10);
            check("vec_cl_q", cl_q, vecs[v].exp_cl_q);
            step();
            check("vec_done_single", cl_done, '0);
        end

        // all clients in the same cycle, twice
        do_reset(2);
        ack_delay = 2;
        for (int r = 0; r < 2; r++) begin
            mark = done_log.size();
            for (int c = 0; c < NC; c++) strobe(c, 1'b0, 23'(c + 16 * r), 2'b11, 16'h0);
            for (int k = 0; k < 60 && done_log.size() < mark + 3; k++) step();
            check("burst_count", done_log.size() - mark, 3);
            for (int k = 0; k < NC; k++)
                if (done_log.size() > mark + k) check("burst_order", done_log[mark + k], k);
        end

        // overrun
        do_reset(2);
        ack_delay = 10;
        strobe(2, 1'b0, 23'h10, 2'b11, 16'h0);
        step();
        step();
        check("ovr_busy", busy, 1'b1);
        strobe(2, 1'b0, 23'h20, 2'b11, 16'h0);
        step();
        check("ovr_flag", cl_ovr[2], 1'b1);
        check("ovr_mem_a", mem_a, 23'h10);
        c0 = done_cnt[2];
        wait_done(2, 30);
        repeat (10) step();
        check("ovr_one_done", done_cnt[2] - c0, 1);
        check("ovr_sticky", cl_ovr[2], 1'b1);

        // reset in the middle of a transfer
        ack_delay = 30;
        strobe(0, 1'b0, 23'h333, 2'b11, 16'h0);
        step();
        step();
        repeat (3) step();
        check("mid_busy", busy, 1'b1);
        sum0 = done_cnt[0] + done_cnt[1] + done_cnt[2];
        do_reset(2);
        check("mid_req_sync", mem_req, mem_ack);
        check("mid_busy0", busy, 1'b0);
        check("mid_ovr_clr", cl_ovr, '0);
        repeat (5) step();
        check("mid_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2] - sum0, 0);
        check("mid_req_sync2", mem_req, mem_ack);
        ack_delay = 2;
        resp_q = 16'h1357;
        strobe(0, 1'b0, 23'h444, 2'b11, 16'h0);
        wait_done(0, 20);
        check("mid_after_q", cl_q, 16'h1357);

        // random traffic against the model
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        ack_delay = 1;
        repeat (60) step();
        check("drain_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one toggle-handshake port of the two-port SDRAM controller (port1 or port2) between several local requesters, such as the CPU data path, the ROM/RAM loader and the DivMMC engine. Each client issues a one-cycle request strobe and receives a one-cycle done pulse with read data. The arbiter latches requests, grants one at a time, drives the controller's toggle `req`, and waits for `ack == req`. It sits between the client logic and the `sdram` port and runs on the SDRAM clock.

## Interface
- `NCLIENT`, 3: number of clients (2..4).
- `AW`, 23: word address width, address bits [23:1].
- `clk` in 1: SDRAM clock, the same clock as the `sdram` block.
- `reset` in 1: **synchronous, active-high**, the only reset.
- `cl_stb` in NCLIENT: one-cycle request strobe per client.
- `cl_we` in NCLIENT: per-client write enable, sampled with `cl_stb`.
- `cl_a` in NCLIENT*AW: packed word addresses; client i uses [i*AW +: AW].
- `cl_ds` in NCLIENT*2: packed byte strobes {upper, lower}.
- `cl_d` in NCLIENT*16: packed write data.
- `cl_done` out NCLIENT: one-cycle completion pulse.
- `cl_q` out 16: read data, shared; valid in the `cl_done` cycle and held until the next completion.
- `cl_ovr` out NCLIENT: sticky overrun flag; a strobe arrived while that client was already pending.
- `mem_req` out 1: toggle request to the controller port.
- `mem_ack` in 1: controller ack; the transfer is complete when `mem_ack == mem_req`.
- `mem_we` out 1: to controller `we`.
- `mem_a` out AW: to controller `a`.
- `mem_ds` out 2: to controller `ds`.
- `mem_d` out 16: to controller `d`.
- `mem_q` in 16: controller `q`, valid in the ack cycle.
- `busy` out 1: high outside IDLE.

## Operation
- **Per-client request latch:** registers `pend[i]`, `we[i]`, `a[i]`, `ds[i]`, `d[i]`.
  - `cl_stb[i]` while `pend[i]==0`: set `pend[i]` and capture the attributes.
  - `cl_stb[i]` while `pend[i]==1`: set `cl_ovr[i]`, ignore the new attributes, keep the original request.
  - `pend[i]` is cleared at its own completion.
  - A strobe in the same cycle as completion of that client is accepted as a new request. This is not an overrun.
- **State machine:** IDLE, WAIT.
  - IDLE with any `pend`: select a grant index `g` round-robin, searching from `last+1` upward with modulo NCLIENT. Drive `mem_we/a/ds/d` from the latch of `g`, toggle `mem_req`, then go to WAIT.
  - IDLE with nothing pending: no change.
  - WAIT, when `mem_ack == mem_req`:
    - register `mem_q` into `cl_q` for reads only (writes leave `cl_q` unchanged);
    - pulse `cl_done[g]`;
    - clear `pend[g]`;
    - set `last <= g`;
    - return to IDLE.
  - WAIT otherwise: hold all `mem_*` outputs stable.
- Back-to-back transfers are supported. The next grant may issue in the cycle after completion (IDLE lasts 1 cycle).
- Only one `mem_req` toggle is outstanding at any time. `mem_*` attributes never change while in WAIT.
- A strobe to a non-granted client during WAIT is latched and served later. It never disturbs the current transfer.

## Timing
- **Reset values:**
  - state = IDLE, `pend = 0`, `cl_done = 0`, `cl_ovr = 0`, `cl_q = 0`, `busy = 0`;
  - `last = NCLIENT-1`, so client 0 wins first;
  - `mem_we = 0`, `mem_a = 0`, `mem_ds = 0`, `mem_d = 0`;
  - `mem_req <= mem_ack`: matched to the controller, so no spurious request is issued.
- **Reset mid-transfer:** the outstanding request is abandoned and `mem_req` is resynchronised to `mem_ack`. No `cl_done` pulse is issued for the abandoned request.
- **Issue latency:**
  - strobe in cycle N → `pend` set in N+1 → `mem_req` toggles at the end of N+1 if IDLE;
  - minimum 2 cycles from strobe to toggle.
- **Completion:**
  - `mem_ack` matches in cycle M (WAIT) → `cl_done[g]` and `cl_q` are registered and visible in M+1, for exactly one cycle;
  - state is IDLE in M+1, and the next toggle is at the end of M+1.
- **`mem_ack` handling:**
  - `mem_ack` is sampled directly because the controller is on the same clock. The controller drives ack combinationally in its read cycle.
  - A mismatch seen in IDLE is impossible by construction and is ignored.
- Simultaneous strobes from all clients in one cycle are served in order `last+1`, `last+2`, … with no starvation. Worst-case wait is NCLIENT-1 transfers.

## Test plan
- **Reset, no traffic:** hold `reset` 3 cycles with `mem_ack=1`, then release → `mem_req=1`, `busy=0`, all `cl_done=0` for 20 cycles.
- **Single read:** client 1 strobes `a=23'h012345`, `we=0`, `ds=2'b11`; the model acks after 8 cycles with `mem_q=16'hBEEF` → `mem_a=23'h012345` stable through WAIT, `cl_done[1]` for 1 cycle, `cl_q=16'hBEEF`.
- **Single write:** client 0 strobes `we=1`, `d=16'h55AA`, `ds=2'b01` → `mem_we=1`, `mem_d=16'h55AA`, `mem_ds=2'b01`; after ack, `cl_done[0]` pulses and `cl_q` keeps its previous value.
- **All clients strobe in the same cycle after reset:** grants in order 0, 1, 2, each completing before the next toggle. A repeat burst is then served 0, 1, 2 again because `last=2`.
- **Overrun:** client 2 strobes twice while pending, with address 0x10 then 0x20 → `cl_ovr[2]=1` (sticky until reset), the transfer uses address 0x10, and only one `cl_done[2]` pulse occurs.
- **Reset mid-transfer:** assert `reset` in WAIT before ack → no `cl_done` pulse, `mem_req==mem_ack` after reset, `pend=0`; a subsequent client 0 strobe completes normally.
